// File: rtl/eth_div.sv
// eth_div: 4-bit by 2-bit restoring divider driven from switches and a
// debounced start button, with the result shown on active-low LEDs.
module eth_div #(
    parameter int unsigned DEB_CYCLES = 12000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] DVD_N,
    input  logic [1:0] DSR_N,
    input  logic       GO_N,
    output logic [3:0] QN,
    output logic [1:0] RN,
    output logic       DONE_N,
    output logic       ERR_N
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, SHOW} state_t;

    // Synchronizer stages (positive logic)
    logic [3:0] dvd_s1_q, dvd_s1_d, dvd_s2_q, dvd_s2_d;
    logic [1:0] dsr_s1_q, dsr_s1_d, dsr_s2_q, dsr_s2_d;
    logic       go_s1_q, go_s1_d, go_s2_q, go_s2_d;

    // Debouncer
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             db_q, db_d;
    logic             press_q, press_d;

    // Control and datapath
    state_t     state_q, state_d;
    logic [3:0] dvd_q, dvd_d;
    logic [1:0] dsr_q, dsr_d;
    logic [2:0] rem_q, rem_d;
    logic [3:0] quo_q, quo_d;
    logic [1:0] iter_q, iter_d;
    logic [3:0] qn_q, qn_d;
    logic [1:0] rn_q, rn_d;
    logic       done_n_q, done_n_d;
    logic       err_n_q, err_n_d;

    // One restoring step
    logic [2:0] rem_sh;
    logic       step_ge;
    logic [2:0] rem_nx;

    // Input synchronizers, inverted to positive logic on the first stage
    always_comb begin
        dvd_s1_d = ~DVD_N;
        dsr_s1_d = ~DSR_N;
        go_s1_d  = ~GO_N;
        dvd_s2_d = dvd_s1_q;
        dsr_s2_d = dsr_s1_q;
        go_s2_d  = go_s1_q;
    end

    // Debounce: the level flips only after the raw level differs for
    // DEB_CYCLES consecutive clocks; the press pulse marks a rising flip.
    // The debounced level comes out of reset as "pressed" so a button held
    // through reset must be released and pressed again before it counts.
    always_comb begin
        deb_cnt_d = '0;
        db_d      = db_q;
        if (go_s2_q != db_q) begin
            if (deb_cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                db_d = go_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
        press_d = db_d & ~db_q;
    end

    // Shift-subtract step: bring in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh  = {rem_q[1:0], dvd_q[3]};
        step_ge = (rem_sh >= {1'b0, dsr_q});
        rem_nx  = step_ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
    end

    // Next-state and datapath/output control
    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        iter_d   = iter_q;
        qn_d     = qn_q;
        rn_d     = rn_q;
        done_n_d = done_n_q;
        err_n_d  = err_n_q;
        case (state_q)
            IDLE, SHOW: begin
                if (press_q) begin
                    state_d  = LOAD;
                    done_n_d = 1'b1;
                end
            end
            LOAD: begin
                dvd_d  = dvd_s2_q;
                dsr_d  = dsr_s2_q;
                rem_d  = 3'd0;
                quo_d  = 4'd0;
                iter_d = 2'd3;
                if (dsr_s2_q == 2'd0) begin
                    state_d  = SHOW;
                    qn_d     = 4'h0;
                    rn_d     = 2'b11;
                    done_n_d = 1'b0;
                    err_n_d  = 1'b0;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d  = rem_nx;
                quo_d  = {quo_q[2:0], step_ge};
                dvd_d  = {dvd_q[2:0], 1'b0};
                iter_d = iter_q - 2'd1;
                if (iter_q == 2'd0) begin
                    state_d  = SHOW;
                    qn_d     = ~{quo_q[2:0], step_ge};
                    rn_d     = ~rem_nx[1:0];
                    done_n_d = 1'b0;
                    err_n_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dvd_s1_q  <= '0;
            dvd_s2_q  <= '0;
            dsr_s1_q  <= '0;
            dsr_s2_q  <= '0;
            go_s1_q   <= 1'b0;
            go_s2_q   <= 1'b0;
            deb_cnt_q <= '0;
            db_q      <= 1'b1;
            press_q   <= 1'b0;
            state_q   <= IDLE;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            iter_q    <= '0;
            qn_q      <= 4'hF;
            rn_q      <= 2'b11;
            done_n_q  <= 1'b1;
            err_n_q   <= 1'b1;
        end else begin
            dvd_s1_q  <= dvd_s1_d;
            dvd_s2_q  <= dvd_s2_d;
            dsr_s1_q  <= dsr_s1_d;
            dsr_s2_q  <= dsr_s2_d;
            go_s1_q   <= go_s1_d;
            go_s2_q   <= go_s2_d;
            deb_cnt_q <= deb_cnt_d;
            db_q      <= db_d;
            press_q   <= press_d;
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            iter_q    <= iter_d;
            qn_q      <= qn_d;
            rn_q      <= rn_d;
            done_n_q  <= done_n_d;
            err_n_q   <= err_n_d;
        end
    end

    assign QN     = qn_q;
    assign RN     = rn_q;
    assign DONE_N = done_n_q;
    assign ERR_N  = err_n_q;

endmodule

// File: tb/tb_eth_div.sv
// Scoreboard bench for eth_div: expected results are queued at each press
// and compared when DONE_N falls.
module tb_eth_div;

    localparam int unsigned DEB = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] dvd_n  = 4'hF;
    logic [1:0] dsr_n  = 2'b11;
    logic       go_n   = 1'b1;
    logic [3:0] qn;
    logic [1:0] rn;
    logic       done_n;
    logic       err_n;

    eth_div #(.DEB_CYCLES(DEB)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .DVD_N  (dvd_n),
        .DSR_N  (dsr_n),
        .GO_N   (go_n),
        .QN     (qn),
        .RN     (rn),
        .DONE_N (done_n),
        .ERR_N  (err_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int err;
    } res_t;

    res_t exp_q[$];
    res_t last_exp;
    res_t mon_e;
    int   vectors   = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   press_cyc = 0;
    int   pulses    = 0;
    logic prev_done = 1'b1;
    logic [3:0] q_act;
    logic [1:0] r_act;

    // Reference: plain integer division, divide-by-zero shows Q=15 R=0
    function automatic res_t model(input int a, input int b);
        res_t m;
        if (b == 0) begin
            m.q = 15; m.r = 0; m.err = 1;
        end else begin
            m.q = a / b; m.r = a % b; m.err = 0;
        end
        return m;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare on each new result
    always @(negedge clk) begin
        cyc++;
        if (dut.press_q) begin
            press_cyc = cyc;
            pulses++;
        end
        if (prev_done && !done_n) begin
            q_act = ~qn;
            r_act = ~rn;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("quotient", int'(q_act), mon_e.q);
                check("remainder", int'(r_act), mon_e.r);
                check("err", int'(!err_n), mon_e.err);
                check("latency", cyc - press_cyc, (mon_e.err != 0) ? 2 : 6);
                last_exp = mon_e;
            end
        end
        prev_done = done_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input int a, input int b);
        dvd_n = ~4'(a);
        dsr_n = ~2'(b);
    endtask

    task automatic wait_pulse(input int start);
        for (int i = 0; i < 200 && pulses == start; i++) @(negedge clk);
        if (pulses == start) check("pulse_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick(1);
    endtask

    task automatic do_press(input int a, input int b);
        set_sw(a, b);
        tick(3);
        exp_q.push_back(model(a, b));
        go_n = 1'b0;
        tick(DEB + 12);
        go_n = 1'b1;
        tick(DEB + 12);
        drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_qn"}, int'(qn), 15);
        check({tag, "_rn"}, int'(rn), 3);
        check({tag, "_done_n"}, int'(done_n), 1);
        check({tag, "_err_n"}, int'(err_n), 1);
    endtask

    initial begin
        int p0;
        int a;
        int b;

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(DEB + 10);

        // Directed divisions, including divide-by-zero
        do_press(13, 3);
        do_press(15, 1);
        do_press(2, 3);
        do_press(0, 2);
        do_press(9, 0);

        // Bouncy press: five short transitions then stable low -> one op
        set_sw(11, 2);
        tick(3);
        exp_q.push_back(model(11, 2));
        go_n = 1'b0; tick(5);
        go_n = 1'b1; tick(4);
        go_n = 1'b0; tick(6);
        go_n = 1'b1; tick(3);
        go_n = 1'b0; tick(DEB + 12);
        go_n = 1'b1; tick(DEB + 12);
        drain();

        // Lone glitch: display must stay as it was
        go_n = 1'b0; tick(4);
        go_n = 1'b1; tick(3 * DEB);
        @(negedge clk);
        q_act = ~qn;
        r_act = ~rn;
        check("glitch_q", int'(q_act), last_exp.q);
        check("glitch_r", int'(r_act), last_exp.r);
        check("glitch_done_n", int'(done_n), 0);

        // Switch changes and button activity during CALC are ignored
        set_sw(14, 3);
        tick(3);
        exp_q.push_back(model(14, 3));
        p0 = pulses;
        go_n = 1'b0;
        wait_pulse(p0);
        tick(2);
        set_sw(5, 1);
        go_n = 1'b1; tick(1);
        go_n = 1'b0; tick(DEB + 5);
        go_n = 1'b1; tick(DEB + 12);
        drain();
        check("one_pulse_only", pulses - p0, 1);

        // Reset mid-CALC aborts; a button held through reset does not fire
        set_sw(13, 3);
        tick(3);
        exp_q.push_back(model(13, 3));
        p0 = pulses;
        go_n = 1'b0;
        wait_pulse(p0);
        tick(3);
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_reset_outputs("abort");
        p0 = pulses;
        tick(3 * DEB);
        check("held_through_reset", pulses - p0, 0);
        go_n = 1'b1;
        tick(DEB + 12);
        do_press(13, 3);

        // Random operands
        for (int i = 0; i < 25; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 3));
            do_press(a, b);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/eth_div.md
ETH_DIV -- requirements
Module: eth_div

Interface
REQ-001 SHALL provide parameter DEB_CYCLES, default 12000, debounce stable-time in clocks (1 ms at 12 MHz).
REQ-002 SHALL provide port CLK, input, 1, system clock (12 MHz icestick oscillator).
REQ-003 SHALL provide port RST_N, input, 1; one clock, reset is synchronous and active-low.
REQ-004 SHALL provide port DVD_N, input, 4, dividend switches, negative logic (low = 1), bit 3 MSB.
REQ-005 SHALL provide port DSR_N, input, 2, divisor switches, negative logic, bit 1 MSB.
REQ-006 SHALL provide port GO_N, input, 1, start pushbutton, negative logic, asynchronous and bouncy.
REQ-007 SHALL provide port QN, output, 4, quotient LEDs, negative logic (low = lit).
REQ-008 SHALL provide port RN, output, 2, remainder LEDs, negative logic.
REQ-009 SHALL provide port DONE_N, output, 1, result-valid LED, negative logic.
REQ-010 SHALL provide port ERR_N, output, 1, divide-by-zero LED, negative logic.

Function
REQ-011 SHALL pass DVD_N, DSR_N, GO_N each through a 2-flop synchronizer and invert to positive logic internally.
REQ-012 SHALL debounce synchronized GO: debounced level changes only after the raw level holds DEB_CYCLES consecutive clocks; shorter pulses are ignored.
REQ-013 SHALL generate a one-clock press pulse on the debounced 0->1 (released->pressed) transition only; a held button produces one pulse.
REQ-014 SHALL implement FSM states IDLE, LOAD, CALC, SHOW.
REQ-015 IDLE: press pulse -> LOAD; otherwise stay.
REQ-016 LOAD (1 clock): capture synchronized dividend and divisor; clear partial remainder; divisor == 0 -> SHOW with error; else -> CALC with iteration count 3.
REQ-017 CALC: one restoring shift-subtract step per clock, MSB first: shift remainder left by 1 and bring in next dividend bit; if remainder >= divisor, subtract and set quotient bit, else clear it; exactly 4 clocks, then -> SHOW.
REQ-018 Remainder datapath SHALL be 3 bits wide so the shifted value never overflows; final remainder SHALL be < divisor and fit in 2 bits.
REQ-019 SHOW entry: register quotient to QN, remainder to RN (inverted), DONE_N=0; ERR_N=0 only for divide-by-zero, with quotient forced to 15 and remainder to 0.
REQ-020 SHOW: outputs hold; press pulse -> LOAD; previous result stays displayed until the new SHOW entry, with DONE_N=1 from LOAD until then.
REQ-021 Latency SHALL be press pulse to SHOW-output update = 6 clocks for nonzero divisor and 2 clocks for zero divisor.
REQ-022 Press pulses during LOAD or CALC SHALL be ignored and not queued.
REQ-023 Switch changes after LOAD SHALL NOT affect the running operation.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 RST_N low at a rising CLK edge SHALL force IDLE, clear the datapath and debouncer, and drive QN=4'hF, RN=2'b11, DONE_N=1, ERR_N=1 (all LEDs off).
REQ-026 Reset asserted during CALC or SHOW SHALL abort the operation with no result displayed; after release, the FSM waits in IDLE for a new press.
REQ-027 A button held through reset release SHALL NOT produce a press pulse until released and pressed again.

Verification
REQ-028 Dividend 13, divisor 3, clean press -> 6 clocks after pulse: QN=~4'd4, RN=~2'd1, DONE_N=0, ERR_N=1.
REQ-029 Dividend 15/1 -> Q=15, R=0; dividend 2/3 -> Q=0, R=2; dividend 0/2 -> Q=0, R=0.
REQ-030 Divisor 0, dividend 9 -> 2 clocks after pulse: QN=4'h0 (Q=15), RN=2'b11, ERR_N=0, DONE_N=0.
REQ-031 GO_N bounce of 5 transitions each shorter than DEB_CYCLES then stable low -> exactly one operation; a glitch alone -> outputs unchanged.
REQ-032 Second press and switch changes during CALC -> first result unaffected; no second operation.
REQ-033 RST_N low for one clock mid-CALC -> all outputs at reset values next clock; a later press computes correctly.
